// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI link blocks.
// Mode decoding tables, word width and the default underrun fill byte.
package spi_pkg;

  localparam int unsigned SPI_BITS  = 8;
  localparam int unsigned SPI_CNT_W = $clog2(SPI_BITS);

  localparam logic [SPI_CNT_W-1:0] BIT_CNT_INIT = SPI_CNT_W'(SPI_BITS - 1);

  // Fill byte shifted out when nothing has been staged.
  localparam logic [SPI_BITS-1:0] IDLE_BYTE_DEFAULT = 8'hFF;

  // Indexed by SPI mode 0..3: CPOL is set for modes 2/3, CPHA for modes 1/3.
  localparam logic [3:0] CPOL_BY_MODE = 4'b1100;
  localparam logic [3:0] CPHA_BY_MODE = 4'b1010;

  typedef logic [SPI_BITS-1:0] spi_byte_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchroniser for one asynchronous pin plus a history
// flop that yields single-cycle rise/fall pulses in the i_Clk domain.
module spi_sync_edge #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Pin,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);

  // [0],[1] are the synchroniser stages, [2] is the edge-detect history.
  logic [2:0] sync_q;

  // Shift the pin through the synchroniser; preset to the pin's idle level
  // so reset release never looks like an edge.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_q <= {3{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[1:0], i_Pin};
    end
  end

  assign o_Level = sync_q[1];
  assign o_Rise  = sync_q[1] & ~sync_q[2];
  assign o_Fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI peripheral-side responder. SCLK, CS_n and MOSI are
// oversampled in the i_Clk domain (i_Clk >= 8x SCLK); nothing runs on SCLK.
// Build macro SPI_SLAVE_STATUS_EN adds sticky o_Overrun/o_Underrun flags and
// the i_Status_Clr input.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned         SPI_MODE  = 0,
  parameter logic [SPI_BITS-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  output logic                o_MOSI_DV,
  output logic [SPI_BITS-1:0] o_MOSI_Byte,
  input  logic                i_MISO_DV,
  input  logic [SPI_BITS-1:0] i_MISO_Byte,
  output logic                o_MISO_Ready,
  input  logic                i_SPI_Clk,
  input  logic                i_SPI_CS_n,
  input  logic                i_SPI_MOSI,
  output logic                o_SPI_MISO,
  output logic                o_SPI_MISO_En
`ifdef SPI_SLAVE_STATUS_EN
  ,
  output logic                o_Overrun,
  output logic                o_Underrun,
  input  logic                i_Status_Clr
`endif
);

  localparam logic CPOL = CPOL_BY_MODE[SPI_MODE[1:0]];
  localparam logic CPHA = CPHA_BY_MODE[SPI_MODE[1:0]];

  logic unused_sclk_level, unused_cs_rise;
  logic sclk_rise, sclk_fall;
  logic cs_level, cs_fall;
  logic mosi_meta_q, mosi_sync_q;

  logic [SPI_CNT_W-1:0] bit_cnt_q;
  spi_byte_t            rx_shift_q;
  logic                 rx_done_q;
  spi_byte_t            tx_shift_q;
  spi_byte_t            hold_byte_q;
  logic                 hold_full_q;

  logic      lead_edge, trail_edge, active, cap_go, shift_go;
  logic      byte_end, boundary, stage;
  spi_byte_t tx_next;

  spi_sync_edge #(
    .IDLE_LEVEL (CPOL)
  ) u_sync_sclk (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Pin   (i_SPI_Clk),
    .o_Level (unused_sclk_level),
    .o_Rise  (sclk_rise),
    .o_Fall  (sclk_fall)
  );

  spi_sync_edge #(
    .IDLE_LEVEL (1'b1)
  ) u_sync_cs (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Pin   (i_SPI_CS_n),
    .o_Level (cs_level),
    .o_Rise  (unused_cs_rise),
    .o_Fall  (cs_fall)
  );

  // MOSI needs no edge detect; two stages keep it aligned with the SCLK edge pulses.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      mosi_meta_q <= i_SPI_MOSI;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign lead_edge  = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge = CPOL ? sclk_rise : sclk_fall;
  assign active     = ~cs_level;
  assign cap_go     = active & (CPHA ? trail_edge : lead_edge);
  assign shift_go   = active & (CPHA ? lead_edge : trail_edge);
  assign byte_end   = cap_go & (bit_cnt_q == '0);
  assign boundary   = cs_fall | byte_end;
  assign tx_next    = hold_full_q ? hold_byte_q : IDLE_BYTE;
  assign stage      = i_MISO_DV & ~hold_full_q;

  assign o_MISO_Ready = ~hold_full_q;

  // Receive path: capture MSB first, publish the byte one cycle after completion.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bit_cnt_q   <= BIT_CNT_INIT;
      rx_shift_q  <= '0;
      rx_done_q   <= 1'b0;
      o_MOSI_DV   <= 1'b0;
      o_MOSI_Byte <= '0;
    end else begin
      rx_done_q <= byte_end;
      o_MOSI_DV <= rx_done_q;
      if (rx_done_q) begin
        o_MOSI_Byte <= rx_shift_q;
      end
      if (!active) begin
        bit_cnt_q <= BIT_CNT_INIT;
      end else if (cap_go) begin
        rx_shift_q[bit_cnt_q] <= mosi_sync_q;
        bit_cnt_q             <= bit_cnt_q - 1'b1;
      end
    end
  end

  // Transmit path. The shared bit counter always names the next bit the master
  // will capture, so with CPHA=0 the trailing edge after a byte boundary simply
  // re-drives the new MSB that the boundary already put out.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tx_shift_q    <= IDLE_BYTE;
      o_SPI_MISO    <= 1'b1;
      o_SPI_MISO_En <= 1'b0;
    end else if (!active) begin
      o_SPI_MISO    <= 1'b1;
      o_SPI_MISO_En <= 1'b0;
    end else begin
      o_SPI_MISO_En <= 1'b1;
      if (boundary) begin
        tx_shift_q <= tx_next;
        if (!CPHA) begin
          o_SPI_MISO <= tx_next[SPI_BITS-1];
        end
      end else if (shift_go) begin
        o_SPI_MISO <= tx_shift_q[bit_cnt_q];
      end
    end
  end

  // Holding register: a boundary drains it, and a same-cycle stage refills it.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hold_full_q <= 1'b0;
      hold_byte_q <= '0;
    end else begin
      if (boundary) begin
        hold_full_q <= 1'b0;
      end
      if (stage) begin
        hold_full_q <= 1'b1;
        hold_byte_q <= i_MISO_Byte;
      end
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  // Sticky error flags; a new event wins over a same-cycle clear.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Overrun  <= 1'b0;
      o_Underrun <= 1'b0;
    end else begin
      if (i_MISO_DV && hold_full_q) begin
        o_Overrun <= 1'b1;
      end else if (i_Status_Clr) begin
        o_Overrun <= 1'b0;
      end
      if (boundary && !hold_full_q) begin
        o_Underrun <= 1'b1;
      end else if (i_Status_Clr) begin
        o_Underrun <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: one spi_slave per SPI mode, each driven by a behavioural
// master; results are compared against a transaction-level model.
// Honours SPI_SLAVE_STATUS_EN for the status flag checks.
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic [3:0] sclk, cs_n, mosi, miso_dv_in;
  logic [7:0] miso_byte_in [4];
  logic [3:0] mosi_dv, ready, miso, miso_en;
  logic [7:0] mosi_byte [4];
  logic [3:0] ovr, unr, clr;

  int total = 0;
  int bad   = 0;

  // Model of the holding register and sticky flags, per mode.
  logic [3:0] m_full, m_ovr, m_unr;
  logic [7:0] m_hold [4];

  logic [15:0] dv_q [$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(
      .SPI_MODE (g)
    ) u_dut (
      .i_Clk         (clk),
      .i_Rst_n       (rst_n),
      .o_MOSI_DV     (mosi_dv[g]),
      .o_MOSI_Byte   (mosi_byte[g]),
      .i_MISO_DV     (miso_dv_in[g]),
      .i_MISO_Byte   (miso_byte_in[g]),
      .o_MISO_Ready  (ready[g]),
      .i_SPI_Clk     (sclk[g]),
      .i_SPI_CS_n    (cs_n[g]),
      .i_SPI_MOSI    (mosi[g]),
      .o_SPI_MISO    (miso[g]),
      .o_SPI_MISO_En (miso_en[g])
`ifdef SPI_SLAVE_STATUS_EN
      ,
      .o_Overrun     (ovr[g]),
      .o_Underrun    (unr[g]),
      .i_Status_Clr  (clr[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every received-byte pulse with its mode.
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (mosi_dv[m]) dv_q.push_back({8'(m), mosi_byte[m]});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic model_boundary(input int m, output logic [7:0] e);
    if (m_full[m]) begin
      e         = m_hold[m];
      m_full[m] = 1'b0;
    end else begin
      e        = 8'hFF;
      m_unr[m] = 1'b1;
    end
  endtask

  task automatic stage(input int m, input logic [7:0] v);
    @(negedge clk);
    miso_dv_in[m]   = 1'b1;
    miso_byte_in[m] = v;
    @(negedge clk);
    miso_dv_in[m] = 1'b0;
    if (m_full[m]) m_ovr[m] = 1'b1;
    else begin
      m_full[m] = 1'b1;
      m_hold[m] = v;
    end
    check_eq("rdy_stage", 32'(ready[m]), 32'(!m_full[m]));
  endtask

  task automatic check_idle(input int m);
    check_eq("idle_dv", 32'(mosi_dv[m]), 32'd0);
    check_eq("idle_byte", 32'(mosi_byte[m]), 32'd0);
    check_eq("idle_rdy", 32'(ready[m]), 32'd1);
    check_eq("idle_miso", 32'(miso[m]), 32'd1);
    check_eq("idle_en", 32'(miso_en[m]), 32'd0);
`ifdef SPI_SLAVE_STATUS_EN
    check_eq("idle_ovr", 32'(ovr[m]), 32'd0);
    check_eq("idle_unr", 32'(unr[m]), 32'd0);
`endif
  endtask

  // Compare flags against the model, then clear both.
  task automatic status_clear(input int m);
`ifdef SPI_SLAVE_STATUS_EN
    check_eq("ovr_flag", 32'(ovr[m]), 32'(m_ovr[m]));
    check_eq("unr_flag", 32'(unr[m]), 32'(m_unr[m]));
    @(negedge clk);
    clr[m] = 1'b1;
    @(negedge clk);
    clr[m] = 1'b0;
    check_eq("ovr_clr", 32'(ovr[m]), 32'd0);
    check_eq("unr_clr", 32'(unr[m]), 32'd0);
`endif
    m_ovr[m] = 1'b0;
    m_unr[m] = 1'b0;
  endtask

  // Full transfer of nb bytes; st_en[k] stages st_val byte k during byte k.
  task automatic xfer(input int m, input int nb, input logic [31:0] tx,
                      input logic [3:0] st_en, input logic [31:0] st_val);
    logic       cpol, cpha;
    logic [7:0] b, r, e;
    logic [7:0] exp_q [$];
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    check_eq("dv_stray", 32'(dv_q.size()), 32'd0);
    dv_q.delete();
    @(negedge clk);
    cs_n[m] = 1'b0;
    model_boundary(m, e);
    exp_q.push_back(e);
    repeat (8) @(negedge clk);
    check_eq("en_active", 32'(miso_en[m]), 32'd1);
    check_eq("rdy_start", 32'(ready[m]), 32'(!m_full[m]));
    for (int k = 0; k < nb; k++) begin
      b = tx[31-8*k -: 8];
      r = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        if (!cpha) begin
          mosi[m] = b[i];
          half();
          sclk[m] = ~cpol;
          r[i]    = miso[m];
          half();
          sclk[m] = cpol;
        end else begin
          sclk[m] = ~cpol;
          mosi[m] = b[i];
          half();
          sclk[m] = cpol;
          r[i]    = miso[m];
          half();
        end
        if (i == 4 && st_en[k]) stage(m, st_val[31-8*k -: 8]);
      end
      check_eq("miso_byte", 32'(r), 32'(exp_q[k]));
      model_boundary(m, e);
      exp_q.push_back(e);
    end
    half();
    cs_n[m] = 1'b1;
    mosi[m] = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("en_idle", 32'(miso_en[m]), 32'd0);
    check_eq("miso_idle", 32'(miso[m]), 32'd1);
    check_eq("rdy_end", 32'(ready[m]), 32'(!m_full[m]));
    check_eq("dv_count", 32'(dv_q.size()), 32'(nb));
    for (int k = 0; k < nb && k < dv_q.size(); k++) begin
      check_eq("dv_byte", 32'(dv_q[k]), 32'({8'(m), tx[31-8*k -: 8]}));
    end
    dv_q.delete();
  endtask

  initial begin
    int nb;
    logic [7:0] e;
    rst_n      = 1'b0;
    cs_n       = 4'hF;
    sclk       = 4'b1100;
    mosi       = 4'h0;
    miso_dv_in = 4'h0;
    clr        = 4'h0;
    m_full     = 4'h0;
    m_ovr      = 4'h0;
    m_unr      = 4'h0;
    for (int m = 0; m < 4; m++) begin
      miso_byte_in[m] = 8'h00;
      m_hold[m]       = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) check_idle(m);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int m = 0; m < 4; m++) check_idle(m);

    // Mode 0: plain receive, unstaged reply.
    xfer(0, 1, 32'hA500_0000, 4'b0000, 32'h0);
    status_clear(0);

    // Mode 0: byte staged before CS_n fall.
    stage(0, 8'h3C);
    xfer(0, 1, 32'h0000_0000, 4'b0000, 32'h0);
    status_clear(0);

    // Modes 1..3: two bytes, second reply staged mid-transfer.
    for (int m = 1; m < 4; m++) begin
      stage(m, 8'hC3);
      xfer(m, 2, 32'h1234_0000, 4'b0001, 32'h5A00_0000);
      status_clear(m);
    end

    // Mode 0: CS_n raised after four bits.
    check_eq("dv_stray", 32'(dv_q.size()), 32'd0);
    dv_q.delete();
    @(negedge clk);
    cs_n[0] = 1'b0;
    model_boundary(0, e);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mosi[0] = 1'b1;
      half();
      sclk[0] = 1'b1;
      half();
      sclk[0] = 1'b0;
    end
    half();
    cs_n[0] = 1'b1;
    mosi[0] = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("abort_nodv", 32'(dv_q.size()), 32'd0);
    check_eq("abort_en", 32'(miso_en[0]), 32'd0);
    check_eq("abort_miso", 32'(miso[0]), 32'd1);
    status_clear(0);
    xfer(0, 1, 32'h0F00_0000, 4'b0000, 32'h0);
    status_clear(0);

    // Mode 0: second stage while full is dropped.
    stage(0, 8'h11);
    stage(0, 8'h77);
    xfer(0, 1, 32'h6600_0000, 4'b0000, 32'h0);
    status_clear(0);

    // Randomised transfers in every mode.
    for (int m = 0; m < 4; m++) begin
      for (int t = 0; t < 3; t++) begin
        nb = int'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) stage(m, 8'($urandom));
        xfer(m, nb, $urandom, 4'($urandom), $urandom);
        status_clear(m);
      end
    end

    // Mode 1: reset in the middle of a byte.
    @(negedge clk);
    cs_n[1] = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sclk[1] = 1'b1;
      mosi[1] = 1'(i);
      half();
      sclk[1] = 1'b0;
      half();
    end
    sclk[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle(1);
    cs_n  = 4'hF;
    sclk  = 4'b1100;
    mosi  = 4'h0;
    m_full = 4'h0;
    m_ovr  = 4'h0;
    m_unr  = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    dv_q.delete();
    xfer(1, 1, 32'h9600_0000, 4'b0000, 32'h0);
    status_clear(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
